// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the N-way perceptron branch predictor.
// Holds the trainer state enum, the dot-product width rule and saturating weight arithmetic.
package perceptron_pkg;

  typedef enum logic [1:0] {INIT, IDLE, CALC, WB} tr_state_e;

  // Bias plus HIST_LEN signed terms can never overflow this width.
  function automatic int sum_w(input int weight_bits, input int hist_len);
    return weight_bits + $clog2(hist_len + 1) + 1;
  endfunction

  // Classic threshold formula; the top-level default is tuned separately.
  function automatic int theta_default(input int hist_len);
    return (193 * hist_len) / 100 + 14;
  endfunction

  function automatic int sat_step(input int val, input logic up, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (up) return (val >= hi) ? hi : val + 1;
    return (val <= lo) ? lo : val - 1;
  endfunction

endpackage

// File: rtl/perceptron_predictor_dot.sv
// Combinational bipolar dot product: bias + sum(h[i] ? +w[i] : -w[i]).
module perceptron_dot
  import perceptron_pkg::*;
#(
  parameter int HIST_LEN    = 16,
  parameter int WEIGHT_BITS = 8,
  parameter int SUM_W       = sum_w(WEIGHT_BITS, HIST_LEN)
) (
  input  logic [HIST_LEN*WEIGHT_BITS-1:0] i_weights,
  input  logic [WEIGHT_BITS-1:0]          i_bias,
  input  logic [HIST_LEN-1:0]             i_hist,
  output logic [SUM_W-1:0]                o_sum
);

  logic signed [SUM_W-1:0]       w_acc;
  logic signed [WEIGHT_BITS-1:0] w_wt;

  always_comb begin
    w_wt  = '0;
    w_acc = SUM_W'($signed(i_bias));
    for (int i = 0; i < HIST_LEN; i++) begin
      w_wt = $signed(i_weights[i*WEIGHT_BITS +: WEIGHT_BITS]);
      if (i_hist[i]) w_acc = w_acc + SUM_W'(w_wt);
      else           w_acc = w_acc - SUM_W'(w_wt);
    end
  end

  assign o_sum = w_acc;

endmodule

// File: rtl/perceptron_predictor_nway.sv
// N-way set-associative perceptron direction predictor with speculative GHR,
// threshold-gated training (IDLE -> CALC -> WB) and a post-reset array init sequencer.
module perceptron_predictor_nway
  import perceptron_pkg::*;
#(
  parameter int NUM_SETS    = 64,
  parameter int WAYS        = 4,
  parameter int HIST_LEN    = 16,
  parameter int WEIGHT_BITS = 8,
  parameter int TAG_BITS    = 14,
  parameter int THETA       = 37
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_pred_valid,
  input  logic [31:0]         i_pred_pc,
  output logic                o_pred_taken,
  output logic [15:0]         o_pred_conf,
  output logic                o_pred_hit,
  output logic [HIST_LEN-1:0] o_pred_hist,
  input  logic                i_train_valid,
  output logic                o_train_ready,
  input  logic [31:0]         i_train_pc,
  input  logic [HIST_LEN-1:0] i_train_hist,
  input  logic                i_train_taken,
  input  logic                i_train_mispredict,
  output logic                o_init_done
);

  localparam int SET_W   = $clog2(NUM_SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int IDX_W   = SET_W + WAY_W;
  localparam int ENTRIES = NUM_SETS * WAYS;
  localparam int SUM_W   = sum_w(WEIGHT_BITS, HIST_LEN);
  localparam int WVEC_W  = HIST_LEN * WEIGHT_BITS;
  localparam int PC_HI   = 2 + SET_W + TAG_BITS;

  logic [WVEC_W-1:0]      r_w     [ENTRIES];
  logic [WEIGHT_BITS-1:0] r_bias  [ENTRIES];
  logic [TAG_BITS-1:0]    r_tag   [ENTRIES];
  logic [WAY_W-1:0]       r_age   [ENTRIES];
  logic [ENTRIES-1:0]     r_valid;

  tr_state_e           r_state, w_state_d;
  logic [IDX_W-1:0]    r_init_cnt;
  logic [HIST_LEN-1:0] r_ghr;
  logic [SET_W-1:0]    r_tset;
  logic [TAG_BITS-1:0] r_ttag;
  logic [HIST_LEN-1:0] r_thist;
  logic                r_ttaken;
  logic [WAY_W-1:0]    r_tway;
  logic                r_thit;
  logic                r_tupd;

  logic w_init_done, w_accept, w_unused_pc;
  assign w_init_done = (r_state != INIT);
  assign w_accept    = (r_state == IDLE) && i_train_valid;
  assign w_unused_pc = ^{i_pred_pc[1:0], i_pred_pc[31:PC_HI], i_train_pc[1:0], i_train_pc[31:PC_HI]};

  // ---------------- prediction lookup ----------------
  logic [SET_W-1:0]    w_pset;
  logic [TAG_BITS-1:0] w_ptag;
  logic                w_phit;
  logic [WAY_W-1:0]    w_pway;
  logic [IDX_W-1:0]    w_pidx;
  logic [SUM_W-1:0]    w_py;
  int                  w_py_int;

  assign w_pset = i_pred_pc[2 +: SET_W];
  assign w_ptag = i_pred_pc[2+SET_W +: TAG_BITS];
  assign w_pidx = {w_pset, w_pway};

  always_comb begin
    w_phit = 1'b0;
    w_pway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[{w_pset, WAY_W'(w)}] && (r_tag[{w_pset, WAY_W'(w)}] == w_ptag)) begin
        w_phit = 1'b1;
        w_pway = WAY_W'(w);
      end
    end
  end

  perceptron_dot #(
    .HIST_LEN   (HIST_LEN),
    .WEIGHT_BITS(WEIGHT_BITS),
    .SUM_W      (SUM_W)
  ) u_dot_pred (
    .i_weights(r_w[w_pidx]),
    .i_bias   (r_bias[w_pidx]),
    .i_hist   (r_ghr),
    .o_sum    (w_py)
  );

  always_comb begin
    w_py_int     = int'($signed(w_py));
    o_pred_hit   = 1'b0;
    o_pred_taken = 1'b0;
    o_pred_conf  = '0;
    if (w_init_done && w_phit) begin
      o_pred_hit   = 1'b1;
      o_pred_taken = ~w_py[SUM_W-1];
      if (w_py_int > 32767)       o_pred_conf = 16'h7fff;
      else if (w_py_int < -32768) o_pred_conf = 16'h8000;
      else                        o_pred_conf = 16'(w_py_int);
    end
  end

  assign o_pred_hist   = r_ghr;
  assign o_init_done   = w_init_done;
  assign o_train_ready = (r_state == IDLE);

  // ---------------- training lookup (CALC) ----------------
  logic                w_thit;
  logic [WAY_W-1:0]    w_thway, w_vway, w_tway;
  logic [IDX_W-1:0]    w_tidx, w_widx;
  logic [SUM_W-1:0]    w_ty;
  int                  w_ty_int;
  logic                w_upd;

  always_comb begin
    w_thit  = 1'b0;
    w_thway = '0;
    w_vway  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[{r_tset, WAY_W'(w)}] && (r_tag[{r_tset, WAY_W'(w)}] == r_ttag)) begin
        w_thit  = 1'b1;
        w_thway = WAY_W'(w);
      end
      if (r_age[{r_tset, WAY_W'(w)}] == WAY_W'(WAYS - 1)) w_vway = WAY_W'(w);
    end
    // Lowest-index invalid way overrides the LRU pick.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[{r_tset, WAY_W'(w)}]) w_vway = WAY_W'(w);
    end
    w_tway = w_thit ? w_thway : w_vway;
  end

  assign w_tidx = {r_tset, w_tway};
  assign w_widx = {r_tset, r_tway};

  perceptron_dot #(
    .HIST_LEN   (HIST_LEN),
    .WEIGHT_BITS(WEIGHT_BITS),
    .SUM_W      (SUM_W)
  ) u_dot_train (
    .i_weights(w_thit ? r_w[w_tidx] : '0),
    .i_bias   (w_thit ? r_bias[w_tidx] : '0),
    .i_hist   (r_thist),
    .o_sum    (w_ty)
  );

  always_comb begin
    w_ty_int = int'($signed(w_ty));
    w_upd    = !w_thit || ((~w_ty[SUM_W-1]) != r_ttaken) ||
               ((w_ty_int <= THETA) && (w_ty_int >= -THETA));
  end

  // ---------------- WB values and LRU next-state ----------------
  logic [WVEC_W-1:0]      w_new_w;
  logic [WEIGHT_BITS-1:0] w_new_bias;
  int                     w_base;
  logic [WAY_W-1:0]       w_page [WAYS];
  logic [WAY_W-1:0]       w_tage [WAYS];
  logic                   w_ptouch, w_ttouch;

  always_comb begin
    w_new_w = '0;
    w_base  = 0;
    for (int i = 0; i < HIST_LEN; i++) begin
      w_base = r_thit ? int'($signed(r_w[w_widx][i*WEIGHT_BITS +: WEIGHT_BITS])) : 0;
      w_new_w[i*WEIGHT_BITS +: WEIGHT_BITS] =
        WEIGHT_BITS'(sat_step(w_base, r_thist[i] == r_ttaken, WEIGHT_BITS));
    end
    w_base     = r_thit ? int'($signed(r_bias[w_widx])) : 0;
    w_new_bias = WEIGHT_BITS'(sat_step(w_base, r_ttaken, WEIGHT_BITS));
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == w_pway)                              w_page[w] = '0;
      else if (r_age[{w_pset, WAY_W'(w)}] < r_age[w_pidx]) w_page[w] = r_age[{w_pset, WAY_W'(w)}] + 1'b1;
      else                                                  w_page[w] = r_age[{w_pset, WAY_W'(w)}];
      if (WAY_W'(w) == r_tway)                              w_tage[w] = '0;
      else if (r_age[{r_tset, WAY_W'(w)}] < r_age[w_widx]) w_tage[w] = r_age[{r_tset, WAY_W'(w)}] + 1'b1;
      else                                                  w_tage[w] = r_age[{r_tset, WAY_W'(w)}];
    end
  end

  assign w_ptouch = w_init_done && i_pred_valid && w_phit;
  assign w_ttouch = (r_state == WB);

  // Arrays carry no reset; the INIT sweep clears them one entry per cycle.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_valid[r_init_cnt] <= 1'b0;
      r_tag[r_init_cnt]   <= '0;
      r_bias[r_init_cnt]  <= '0;
      r_w[r_init_cnt]     <= '0;
      // Ages start as a permutation (age = way) so exactly one way is always oldest.
      r_age[r_init_cnt]   <= r_init_cnt[WAY_W-1:0];
    end else begin
      if (w_ptouch && !(w_ttouch && (w_pset == r_tset))) begin
        for (int w = 0; w < WAYS; w++) r_age[{w_pset, WAY_W'(w)}] <= w_page[w];
      end
      if (w_ttouch) begin
        for (int w = 0; w < WAYS; w++) r_age[{r_tset, WAY_W'(w)}] <= w_tage[w];
        if (r_tupd) begin
          r_w[w_widx]    <= w_new_w;
          r_bias[w_widx] <= w_new_bias;
        end
        if (!r_thit) begin
          r_valid[w_widx] <= 1'b1;
          r_tag[w_widx]   <= r_ttag;
        end
      end
    end
  end

  // ---------------- FSM and control state ----------------
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      INIT:    if (r_init_cnt == IDX_W'(ENTRIES - 1)) w_state_d = IDLE;
      IDLE:    if (i_train_valid) w_state_d = CALC;
      CALC:    w_state_d = WB;
      WB:      w_state_d = IDLE;
      default: w_state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_ghr      <= '0;
      r_tset     <= '0;
      r_ttag     <= '0;
      r_thist    <= '0;
      r_ttaken   <= 1'b0;
      r_tway     <= '0;
      r_thit     <= 1'b0;
      r_tupd     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_accept) begin
        r_tset   <= i_train_pc[2 +: SET_W];
        r_ttag   <= i_train_pc[2+SET_W +: TAG_BITS];
        r_thist  <= i_train_hist;
        r_ttaken <= i_train_taken;
      end
      if (r_state == CALC) begin
        r_tway <= w_tway;
        r_thit <= w_thit;
        r_tupd <= w_upd;
      end
      // Repair at the accept edge beats a same-cycle speculative shift.
      if (w_accept && i_train_mispredict) r_ghr <= {i_train_hist[HIST_LEN-2:0], i_train_taken};
      else if (i_pred_valid && w_init_done) r_ghr <= {r_ghr[HIST_LEN-2:0], o_pred_taken};
    end
  end

endmodule

// File: tb/tb_perceptron_predictor_nway.sv
// Directed, table-driven bench for perceptron_predictor_nway (default config plus a
// narrow-weight, always-train instance for saturation).
`timescale 1ns/1ps
module tb_perceptron_predictor_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        pv, pt, phit, tv, tr, tt, tm, idone;
  logic [31:0] ppc, tpc;
  logic [15:0] pconf, phist, thist;

  logic        s_pv, s_pt, s_phit, s_tv, s_tr, s_tt, s_tm, s_idone;
  logic [31:0] s_ppc, s_tpc;
  logic [15:0] s_pconf, s_phist, s_thist;

  int n_cmp = 0;
  int n_bad = 0;

  perceptron_predictor_nway u_dut (
    .clk(clk), .rst(rst),
    .i_pred_valid(pv), .i_pred_pc(ppc),
    .o_pred_taken(pt), .o_pred_conf(pconf), .o_pred_hit(phit), .o_pred_hist(phist),
    .i_train_valid(tv), .o_train_ready(tr), .i_train_pc(tpc), .i_train_hist(thist),
    .i_train_taken(tt), .i_train_mispredict(tm), .o_init_done(idone)
  );

  perceptron_predictor_nway #(
    .NUM_SETS(4), .WAYS(2), .HIST_LEN(16), .WEIGHT_BITS(4), .TAG_BITS(14), .THETA(1000)
  ) u_small (
    .clk(clk), .rst(rst),
    .i_pred_valid(s_pv), .i_pred_pc(s_ppc),
    .o_pred_taken(s_pt), .o_pred_conf(s_pconf), .o_pred_hit(s_phit), .o_pred_hist(s_phist),
    .i_train_valid(s_tv), .o_train_ready(s_tr), .i_train_pc(s_tpc), .i_train_hist(s_thist),
    .i_train_taken(s_tt), .i_train_mispredict(s_tm), .o_init_done(s_idone)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] hist;
    logic        taken;
    logic [15:0] exp_conf;
  } thr_vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        exp_hit;
    logic [15:0] exp_conf;
  } probe_vec_t;

  thr_vec_t   thr [3];
  probe_vec_t lru [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!tr && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, tr}, 32'd1);
  endtask

  task automatic train(input logic [31:0] pc, input logic [15:0] h, input logic t, input logic m);
    @(negedge clk);
    wait_ready("train_ready_idle");
    tpc = pc; thist = h; tt = t; tm = m; tv = 1'b1;
    @(posedge clk);
    #1 tv = 1'b0; tm = 1'b0;
    wait_ready("train_done");
  endtask

  task automatic train_s(input logic [31:0] pc, input logic [15:0] h, input logic t, input logic m);
    int k;
    @(negedge clk);
    s_tpc = pc; s_thist = h; s_tt = t; s_tm = m; s_tv = 1'b1;
    @(posedge clk);
    #1 s_tv = 1'b0; s_tm = 1'b0;
    k = 0;
    while (!s_tr && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!s_tr) check("small_train_done", {31'd0, s_tr}, 32'd1);
  endtask

  task automatic probe(input logic [31:0] pc);
    @(negedge clk);
    pv = 1'b0; ppc = pc;
    #1;
  endtask

  task automatic count_init(input string name);
    int k;
    k = 0;
    while (!idone && k < 400) begin
      @(posedge clk);
      #1 k++;
      if (k == 100) begin
        check("init_pred_hit", {31'd0, phit}, 32'd0);
        check("init_train_ready", {31'd0, tr}, 32'd0);
        check("init_ghr_hold", {16'd0, phist}, 32'd0);
      end
    end
    check(name, k, 32'd256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    thr[0] = '{32'h100, 16'h0000, 1'b1, 16'd34};
    thr[1] = '{32'h100, 16'h0000, 1'b1, 16'd51};
    thr[2] = '{32'h100, 16'h0000, 1'b1, 16'd51};
    lru[0] = '{32'h100, 1'b0, 16'd0};
    lru[1] = '{32'h200, 1'b1, 16'd17};
    lru[2] = '{32'h300, 1'b1, 16'd17};
    lru[3] = '{32'h400, 1'b1, 16'd17};
    lru[4] = '{32'h500, 1'b1, 16'd17};

    rst = 1'b1;
    pv = 0; ppc = 0; tv = 0; tpc = 0; thist = 0; tt = 0; tm = 0;
    s_pv = 0; s_ppc = 0; s_tv = 0; s_tpc = 0; s_thist = 0; s_tt = 0; s_tm = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pred_taken", {31'd0, pt}, 32'd0);
    check("rst_pred_conf", {16'd0, pconf}, 32'd0);
    check("rst_pred_hit", {31'd0, phit}, 32'd0);
    check("rst_pred_hist", {16'd0, phist}, 32'd0);
    check("rst_train_ready", {31'd0, tr}, 32'd0);
    check("rst_init_done", {31'd0, idone}, 32'd0);

    @(negedge clk);
    rst = 1'b0; pv = 1'b1; ppc = 32'h100;
    count_init("init_cycles");
    pv = 1'b0;
    @(negedge clk);
    check("ghr_after_init", {16'd0, phist}, 32'd0);

    // Cold allocate with latency observation.
    tpc = 32'h100; thist = 16'h0; tt = 1'b1; tm = 1'b0; tv = 1'b1;
    @(posedge clk);
    #1 tv = 1'b0;
    check("ready_calc", {31'd0, tr}, 32'd0);
    @(posedge clk);
    #1 check("ready_wb", {31'd0, tr}, 32'd0);
    @(posedge clk);
    #1 check("ready_back", {31'd0, tr}, 32'd1);
    probe(32'h100);
    check("alloc_hit", {31'd0, phit}, 32'd1);
    check("alloc_conf", {16'd0, pconf}, 32'd17);
    check("alloc_taken", {31'd0, pt}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      train(thr[i].pc, thr[i].hist, thr[i].taken, 1'b0);
      probe(thr[i].pc);
      check($sformatf("thr_conf[%0d]", i), {16'd0, pconf}, {16'd0, thr[i].exp_conf});
    end

    // Three speculative predictions on the trained entry (w=-3, bias=+3).
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pv = 1'b1; ppc = 32'h100;
      #1;
      check($sformatf("ghr_shift_hist[%0d]", i), {16'd0, phist}, (i == 0) ? 32'd0 : (i == 1) ? 32'd1 : 32'd3);
      check($sformatf("ghr_shift_conf[%0d]", i), {16'd0, pconf}, (i == 0) ? 32'd51 : (i == 1) ? 32'd45 : 32'd39);
    end
    @(negedge clk);
    pv = 1'b0;
    #1 check("ghr_after_shifts", {16'd0, phist}, 32'd7);

    // Repair with a simultaneous prediction.
    @(negedge clk);
    pv = 1'b1; ppc = 32'h100; tpc = 32'h104; thist = 16'h0005; tt = 1'b0; tm = 1'b1; tv = 1'b1;
    @(posedge clk);
    #1 tv = 1'b0; tm = 1'b0; pv = 1'b0;
    check("ghr_repair", {16'd0, phist}, 32'h000A);
    wait_ready("repair_train_done");

    // Reset in the middle of a training request.
    @(negedge clk);
    tpc = 32'h200; thist = 16'h0; tt = 1'b1; tv = 1'b1;
    @(posedge clk);
    #1 tv = 1'b0;
    @(negedge clk);
    rst = 1'b1; pv = 1'b1; ppc = 32'h100;
    #1;
    check("midrst_train_ready", {31'd0, tr}, 32'd0);
    check("midrst_init_done", {31'd0, idone}, 32'd0);
    check("midrst_pred_hist", {16'd0, phist}, 32'd0);
    check("midrst_pred_hit", {31'd0, phit}, 32'd0);
    @(negedge clk);
    rst = 1'b0; pv = 1'b0;
    count_init("reinit_cycles");
    probe(32'h100);
    check("reinit_cleared", {31'd0, phit}, 32'd0);

    // LRU: five PCs in set 0; E must evict A.
    train(32'h100, 16'h0, 1'b1, 1'b0);
    train(32'h200, 16'h0, 1'b1, 1'b0);
    train(32'h300, 16'h0, 1'b1, 1'b0);
    train(32'h400, 16'h0, 1'b1, 1'b0);
    train(32'h500, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      probe(lru[i].pc);
      check($sformatf("lru_hit[%0d]", i), {31'd0, phit}, {31'd0, lru[i].exp_hit});
      check($sformatf("lru_conf[%0d]", i), {16'd0, pconf}, {16'd0, lru[i].exp_conf});
    end

    // Saturation on the 4-bit-weight instance.
    check("small_init_done", {31'd0, s_idone}, 32'd1);
    for (int i = 0; i < 200; i++) train_s(32'h0, 16'h00FF, 1'b1, 1'b0);
    @(negedge clk);
    s_ppc = 32'h0;
    #1;
    check("sat_hit", {31'd0, s_phit}, 32'd1);
    check("sat_conf_ghr0", {16'd0, s_pconf}, 32'd15);
    train_s(32'h4, 16'h007F, 1'b1, 1'b1);
    @(negedge clk);
    s_ppc = 32'h0;
    #1;
    check("sat_ghr", {16'd0, s_phist}, 32'h00FF);
    check("sat_conf_ghrff", {16'd0, s_pconf}, 32'd127);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
